// File: rtl/line_transform_engine.sv
// Line transform engine: captures one terminal line into a local buffer,
// then streams a transformed copy (echo / upper / reverse / lower) to the
// video-memory line writer and closes with the solved handshake.
module line_transform_engine #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6,
    parameter int CHAR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              out_newASCII_ready,
    input  logic [LEN_W-1:0]  out_lineLen,
    input  logic [CHAR_W-1:0] lineOut,
    output logic              lineOut_nextASCII,
    output logic              in_newASCII_ready,
    output logic [CHAR_W-1:0] lineIn,
    input  logic              lineIn_nextASCII,
    output logic              in_solved,
    input  logic              out_solved,
    output logic              busy,
    output logic              overflow
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_EMIT    = 3'd3,
        ST_SOLVED  = 3'd4
    } state_t;

    state_t            state_r, state_next_s;
    logic [LEN_W-1:0]  wr_idx_r, rd_idx_r, len_r;
    logic [1:0]        mode_r;
    logic              pulse_r, in_rdy_r, solved_r, overflow_r, busy_r;
    logic [CHAR_W-1:0] line_buf_r [MAX_LEN];

    logic              start_s, cap_char_s, cap_done_s;
    logic              emit_start_s, step_s, emit_done_s, ack_s;
    logic [IDX_W-1:0]  rd_pos_s;
    logic [CHAR_W-1:0] line_in_s;

    // Character transform: case folding for modes 1 and 3, identity otherwise.
    function automatic logic [CHAR_W-1:0] xform(input logic [1:0] m, input logic [CHAR_W-1:0] c);
        logic [CHAR_W-1:0] r;
        r = c;
        case (m)
            2'd1: begin
                if (c >= CHAR_W'(8'h61) && c <= CHAR_W'(8'h7A)) r = c - CHAR_W'(8'h20);
                else r = c;
            end
            2'd3: begin
                if (c >= CHAR_W'(8'h41) && c <= CHAR_W'(8'h5A)) r = c + CHAR_W'(8'h20);
                else r = c;
            end
            default: r = c;
        endcase
        return r;
    endfunction

    // Next-state decode plus one-hot action strobes for the datapath.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        cap_char_s   = 1'b0;
        cap_done_s   = 1'b0;
        emit_start_s = 1'b0;
        step_s       = 1'b0;
        emit_done_s  = 1'b0;
        ack_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (out_newASCII_ready) begin
                    start_s      = 1'b1;
                    state_next_s = ST_CAPTURE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                // A pulse cycle is never a capture cycle, so pulses stay non-adjacent.
                if (out_newASCII_ready && !pulse_r) begin
                    if (wr_idx_r == out_lineLen) begin
                        cap_done_s   = 1'b1;
                        state_next_s = ST_DRAIN;
                    end else begin
                        cap_char_s   = 1'b1;
                        state_next_s = ST_CAPTURE;
                    end
                end else begin
                    state_next_s = ST_CAPTURE;
                end
            end
            ST_DRAIN: begin
                if (!out_newASCII_ready) begin
                    emit_start_s = 1'b1;
                    state_next_s = ST_EMIT;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_EMIT: begin
                step_s = lineIn_nextASCII && (rd_idx_r < len_r);
                if ((rd_idx_r == len_r) && in_rdy_r) begin
                    emit_done_s  = 1'b1;
                    state_next_s = ST_SOLVED;
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            ST_SOLVED: begin
                if (out_solved) begin
                    ack_s        = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SOLVED;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_next_s;
    end

    // Indices, clamped length, latched mode and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_r   <= '0;
            rd_idx_r   <= '0;
            len_r      <= '0;
            mode_r     <= 2'd0;
            overflow_r <= 1'b0;
        end else begin
            if (start_s) begin
                mode_r     <= mode;
                overflow_r <= 1'b0;
                wr_idx_r   <= '0;
            end else if (cap_char_s) begin
                wr_idx_r <= wr_idx_r + LEN_W'(1);
                if (wr_idx_r >= MAX_LEN_L) overflow_r <= 1'b1;
                else                       overflow_r <= overflow_r;
            end else begin
                wr_idx_r <= wr_idx_r;
            end
            if (cap_done_s) len_r <= (out_lineLen > MAX_LEN_L) ? MAX_LEN_L : out_lineLen;
            else            len_r <= len_r;
            if (emit_start_s) rd_idx_r <= '0;
            else if (step_s)  rd_idx_r <= rd_idx_r + LEN_W'(1);
            else              rd_idx_r <= rd_idx_r;
        end
    end

    // Handshake outputs: consume pulse, stream-valid, solved, busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_r  <= 1'b0;
            in_rdy_r <= 1'b0;
            solved_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            pulse_r <= cap_char_s;
            busy_r  <= (state_next_s != ST_IDLE);
            if (emit_start_s)     in_rdy_r <= 1'b1;
            else if (emit_done_s) in_rdy_r <= 1'b0;
            else                  in_rdy_r <= in_rdy_r;
            if (emit_done_s) solved_r <= 1'b1;
            else if (ack_s)  solved_r <= 1'b0;
            else             solved_r <= solved_r;
        end
    end

    // Line store; characters beyond MAX_LEN are consumed but dropped.
    always_ff @(posedge clk) begin
        if (cap_char_s && (wr_idx_r < MAX_LEN_L)) line_buf_r[wr_idx_r[IDX_W-1:0]] <= lineOut;
    end

    // Read port: reverse mode walks from the tail, terminator once rd_idx reaches len.
    always_comb begin
        if (mode_r == 2'd2) rd_pos_s = IDX_W'(len_r - LEN_W'(1) - rd_idx_r);
        else                rd_pos_s = IDX_W'(rd_idx_r);
        if (!in_rdy_r || (rd_idx_r == len_r)) line_in_s = '0;
        else                                   line_in_s = xform(mode_r, line_buf_r[rd_pos_s]);
    end

    assign lineOut_nextASCII = pulse_r;
    assign in_newASCII_ready = in_rdy_r;
    assign in_solved         = solved_r;
    assign busy              = busy_r;
    assign overflow          = overflow_r;
    assign lineIn            = line_in_s;

endmodule

// File: tb/tb_line_transform_engine.sv
// Directed bench for line_transform_engine (MAX_LEN=4 so overflow is reachable).
module tb_line_transform_engine;

    localparam int MAX_LEN = 4;
    localparam int LEN_W   = 6;
    localparam int CHAR_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic              out_newASCII_ready;
    logic [LEN_W-1:0]  out_lineLen;
    logic [CHAR_W-1:0] lineOut;
    logic              lineOut_nextASCII;
    logic              in_newASCII_ready;
    logic [CHAR_W-1:0] lineIn;
    logic              lineIn_nextASCII;
    logic              in_solved;
    logic              out_solved;
    logic              busy;
    logic              overflow;

    int errors = 0;
    int checks = 0;

    line_transform_engine #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CHAR_W(CHAR_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mode               (mode),
        .out_newASCII_ready (out_newASCII_ready),
        .out_lineLen        (out_lineLen),
        .lineOut            (lineOut),
        .lineOut_nextASCII  (lineOut_nextASCII),
        .in_newASCII_ready  (in_newASCII_ready),
        .lineIn             (lineIn),
        .lineIn_nextASCII   (lineIn_nextASCII),
        .in_solved          (in_solved),
        .out_solved         (out_solved),
        .busy               (busy),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pulse"},  lineOut_nextASCII, 0);
        check({tag, "_rdy"},    in_newASCII_ready, 0);
        check({tag, "_solved"}, in_solved, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_ovf"},    overflow, 0);
        check({tag, "_linein"}, lineIn, 0);
    endtask

    // Terminal side: present the line, advance on every consume pulse,
    // hold ready until the engine has seen wr_idx==len (2n+2 edges).
    task automatic send_line(input string s, output int pulses);
        int n = s.len();
        int idx = 0;
        pulses = 0;
        out_lineLen = LEN_W'(n);
        lineOut = (n > 0) ? s[0] : 8'h00;
        out_newASCII_ready = 1'b1;
        for (int e = 0; e < 2 * n + 2; e++) begin
            tick();
            if (lineOut_nextASCII) begin
                pulses++;
                idx++;
                lineOut = (idx < n) ? s[idx] : 8'h00;
            end
        end
        out_newASCII_ready = 1'b0;
        lineOut = 8'h00;
    endtask

    task automatic wait_rdy(input string tag);
        int w = 0;
        while (!in_newASCII_ready && w < 20) begin
            tick();
            w++;
        end
        check({tag, "_rdy_wait"}, in_newASCII_ready, 1);
    endtask

    // Writer side: check each character, ack it, then terminator and in_solved rise.
    task automatic recv_line(input string tag, input string exp, input int chg_at);
        wait_rdy(tag);
        for (int i = 0; i < exp.len(); i++) begin
            check($sformatf("%s_ch%0d", tag, i), lineIn, exp[i]);
            lineIn_nextASCII = 1'b1;
            tick();
            lineIn_nextASCII = 1'b0;
            if (i == chg_at) mode = 2'd0;
        end
        check({tag, "_term"}, lineIn, 0);
        check({tag, "_solved_pre"}, in_solved, 0);
        tick();
        check({tag, "_solved_rise"}, in_solved, 1);
        check({tag, "_rdy_fall"}, in_newASCII_ready, 0);
    endtask

    // Video memory side: in_solved must hold until the acknowledge pulse.
    task automatic ack_solved(input string tag);
        tick();
        tick();
        check({tag, "_hold"}, in_solved, 1);
        check({tag, "_busy_hold"}, busy, 1);
        out_solved = 1'b1;
        tick();
        out_solved = 1'b0;
        check({tag, "_cleared"}, in_solved, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        rst_n = 1'b0;
        mode = 2'd0;
        out_newASCII_ready = 1'b0;
        out_lineLen = '0;
        lineOut = '0;
        lineIn_nextASCII = 1'b0;
        out_solved = 1'b0;
        #3;
        check_quiet("reset");
        #9 rst_n = 1'b1;
        tick();

        // 1: echo "ls"
        mode = 2'd0;
        send_line("ls", p);
        check("t1_pulses", p, 2);
        recv_line("t1", "ls", -1);
        ack_solved("t1");

        // 2: uppercase "aZ9", lowercase "Ab"
        mode = 2'd1;
        send_line("aZ9", p);
        check("t2u_pulses", p, 3);
        recv_line("t2u", "AZ9", -1);
        ack_solved("t2u");
        mode = 2'd3;
        send_line("Ab", p);
        recv_line("t2l", "ab", -1);
        ack_solved("t2l");

        // 3: reverse "abc", mode changed to echo after first char
        mode = 2'd2;
        send_line("abc", p);
        recv_line("t3", "cba", 0);
        ack_solved("t3");

        // 4: overflow, 6 chars into a 4-deep store
        mode = 2'd0;
        send_line("abcdef", p);
        check("t4_pulses", p, 6);
        check("t4_ovf", overflow, 1);
        recv_line("t4", "abcd", -1);
        ack_solved("t4");
        check("t4_ovf_kept", overflow, 1);
        send_line("xy", p);
        check("t4_ovf_cleared", overflow, 0);
        recv_line("t4b", "xy", -1);
        ack_solved("t4b");

        // 5: zero-length line
        send_line("", p);
        check("t5_pulses", p, 0);
        recv_line("t5", "", -1);
        ack_solved("t5");

        // 6a: reset mid-CAPTURE after one character
        out_lineLen = LEN_W'(2);
        lineOut = 8'h68;
        out_newASCII_ready = 1'b1;
        tick();
        tick();
        check("t6a_pulse", lineOut_nextASCII, 1);
        #2 rst_n = 1'b0;
        #1;
        check_quiet("t6a");
        out_newASCII_ready = 1'b0;
        lineOut = 8'h00;
        #2 rst_n = 1'b1;
        tick();
        check("t6a_no_solved", in_solved, 0);

        // 6b: reset mid-EMIT
        send_line("ab", p);
        wait_rdy("t6b");
        check("t6b_ch0", lineIn, 8'h61);
        #2 rst_n = 1'b0;
        #1;
        check_quiet("t6b");
        #2 rst_n = 1'b1;
        tick();
        tick();
        check("t6b_no_solved", in_solved, 0);

        // 6c: fresh line after reset
        send_line("hi", p);
        check("t6c_pulses", p, 2);
        recv_line("t6c", "hi", -1);
        ack_solved("t6c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
